mult_div_hilo: RTL
==================

Name: mult_div_hilo

Overview:
- Sits directly downstream of the ALU control decoder, beside the main ALU. Consumes its 4-bit ALU opcode and Unsigned flag for the MULT/DIV/MFLO/MFHI group.
- Performs iterative multi-cycle multiply (shift-add) and divide (restoring) into architectural HI/LO registers.
- Serves MFLO/MFHI reads and tells the datapath when the PC must be stalled.

Parameters:
- DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  instruction in execute is valid this cycle.
- ULAopcode  in  4  from ALU control: 1000 MULT, 1001 DIV, 1010 MFLO, 1011 MFHI; other codes are ignored by this block.
- Unsigned  in  1  1 = unsigned operation (MULTU/DIVU), 0 = signed.
- op_a  in  DATA_W  rs value (multiplicand / dividend).
- op_b  in  DATA_W  rt value (multiplier / divisor).
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.
- rd_data  out  DATA_W  combinational: hi when ULAopcode=1011, lo when 1010, else 0.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO are written.
- stall  out  1  PC/pipeline hold request.

Behaviour:
- Reset: rst_n=0 sampled at a rising edge forces state IDLE, hi=lo=0, busy=0, done=0, counter=0 and internal accumulators=0. Reset mid-operation aborts the operation; no HI/LO write occurs.
- States: IDLE, RUN, SIGN.
- IDLE to RUN: at the edge where start=1 and ULAopcode is 1000 or 1001 ("accept edge", E0).
  - Latch the op kind.
  - Latch sign flags: neg_a = op_a[MSB] & ~Unsigned, neg_b = op_b[MSB] & ~Unsigned.
  - Latch operand magnitudes (two's-complement negate when the sign flag is set).
  - Clear the counter.
- RUN: one iteration per edge, E1..E(DATA_W).
  - Multiply: LSB-first shift-add into a 2*DATA_W product.
  - Divide: restoring shift-subtract producing a DATA_W quotient and remainder.
  - At the edge with counter = DATA_W-1, go to SIGN.
- SIGN, at edge E(DATA_W+1), then IDLE:
  - MULT: {hi,lo} = product, negated as a 2*DATA_W quantity when neg_a^neg_b.
  - DIV: lo = quotient, negated when neg_a^neg_b; hi = remainder, negated when neg_a. The remainder sign follows the dividend.
  - done=1 for exactly the cycle after this edge.
- Latency: HI/LO valid and done=1 after edge E33 for DATA_W=32.
- busy = 1 while state is RUN or SIGN.
- Divide by zero (op_b=0), any signedness, is defined: lo = all ones, hi = op_a unchanged. Result is written after the same latency; no exception is raised.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude algorithm.
- start with MULT/DIV while busy: ignored. The datapath must not issue it because stall is high.
- stall = busy | (start & (ULAopcode==1000 | ULAopcode==1001) & state==IDLE).
  - The issuing instruction holds the PC from E0 through SIGN.
  - The PC advances on the edge after done.
- MFLO/MFHI while busy: stall=1 (covered by busy) and rd_data shows the stale register. The consumer must not write back while stall=1.
- MFLO/MFHI when idle: rd_data is valid combinationally in the same cycle; HI/LO unchanged.
- MFLO/MFHI in the done cycle: returns the new value, since HI/LO were written at E33.
- hi/lo change only at SIGN or reset.

Test Plan:
- Reset: rst_n=0 for 2 edges mid-DIV (e.g. at E10) -> hi=lo=0, busy=0, done never pulses; next op behaves normally.
- Signed MULT: op_a=0xFFFFFFFD (-3), op_b=7, Unsigned=0 -> after E33 hi=0xFFFFFFFF, lo=0xFFFFFFEB, done high 1 cycle, busy low from E33.
- Unsigned MULT: op_a=op_b=0xFFFFFFFF, Unsigned=1 -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed DIV: op_a=-7 (0xFFFFFFF9), op_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Unsigned 7/2 -> lo=3, hi=1.
- Divide corners:
  - op_b=0, op_a=0x1234 -> lo=0xFFFFFFFF, hi=0x1234.
  - 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0.
- Interlock: MFHI issued at E5 of a MULT -> stall=1, no HI change until E33; MFHI in the done cycle -> rd_data = new hi. A second MULT start during busy is ignored (hi/lo reflect only the first).

Source files
------------

// File: rtl/mult_div_hilo.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up in a final cycle and MFLO/MFHI read-out.
module mult_div_hilo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        ULAopcode,
    input  logic              Unsigned,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              stall
);

    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFLO = 4'b1010;
    localparam logic [3:0] OP_MFHI = 4'b1011;

    localparam int                CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_is_div;
    logic                r_neg_a;
    logic                r_neg_b;
    logic                r_div_zero;
    logic [CNT_W-1:0]    r_cnt;
    // r_opnd holds the operand that stays fixed across iterations (multiplicand or
    // divisor); r_acc_hi/r_acc_lo are product halves or remainder/quotient.
    logic [DATA_W-1:0]   r_opnd;
    logic [DATA_W-1:0]   r_acc_hi;
    logic [DATA_W-1:0]   r_acc_lo;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;

    logic                w_is_muldiv;
    logic                w_accept;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_div_shift;
    logic [DATA_W-1:0]   w_div_sub;
    logic                w_div_fits;
    logic [DATA_W-1:0]   w_step_hi;
    logic [DATA_W-1:0]   w_step_lo;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;

    assign w_is_muldiv = (ULAopcode == OP_MULT) | (ULAopcode == OP_DIV);
    assign w_accept    = start & w_is_muldiv & (r_state == IDLE);
    assign w_neg_a     = op_a[DATA_W-1] & ~Unsigned;
    assign w_neg_b     = op_b[DATA_W-1] & ~Unsigned;
    assign w_mag_a     = w_neg_a ? -op_a : op_a;
    assign w_mag_b     = w_neg_b ? -op_b : op_b;

    // The true difference is below 2^DATA_W whenever it is kept, so modular subtraction suffices.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = {r_acc_hi, r_acc_lo[DATA_W-1]};
    assign w_div_fits  = w_div_shift >= {1'b0, r_opnd};
    assign w_div_sub   = w_div_shift[DATA_W-1:0] - r_opnd;
    assign w_prod      = {r_acc_hi, r_acc_lo};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_step_hi = w_mul_sum[DATA_W:1];
        w_step_lo = {w_mul_sum[0], r_acc_lo[DATA_W-1:1]};
        if (r_is_div) begin
            w_step_hi = w_div_fits ? w_div_sub : w_div_shift[DATA_W-1:0];
            w_step_lo = {r_acc_lo[DATA_W-2:0], w_div_fits};
        end
    end

    always_comb begin
        {w_res_hi, w_res_lo} = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
        if (r_is_div) begin
            w_res_hi = r_neg_a ? -r_acc_hi : r_acc_hi;
            if (r_div_zero) begin
                w_res_lo = '1;
            end else begin
                w_res_lo = (r_neg_a ^ r_neg_b) ? -r_acc_lo : r_acc_lo;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = RUN;
            RUN:     if (r_cnt == LAST_ITER) w_next_state = SIGN;
            SIGN:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: the datapath registers are few and all reset, so an abort leaves no stale partial result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_is_div   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
            r_opnd     <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == SIGN);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_div   <= (ULAopcode == OP_DIV);
                        r_neg_a    <= w_neg_a;
                        r_neg_b    <= w_neg_b;
                        r_div_zero <= (op_b == '0);
                        r_cnt      <= '0;
                        r_acc_hi   <= '0;
                        if (ULAopcode == OP_DIV) begin
                            r_opnd   <= w_mag_b;
                            r_acc_lo <= w_mag_a;
                        end else begin
                            r_opnd   <= w_mag_a;
                            r_acc_lo <= w_mag_b;
                        end
                    end
                end
                RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                SIGN: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign done  = r_done;
    assign busy  = (r_state != IDLE);
    assign stall = busy | w_accept;

    always_comb begin
        rd_data = '0;
        if (ULAopcode == OP_MFHI) begin
            rd_data = r_hi;
        end else if (ULAopcode == OP_MFLO) begin
            rd_data = r_lo;
        end
    end

endmodule
